// File: rtl/control_unit.sv
// Multi-cycle sequencer driving every control input of the CPU datapath.
// Control outputs are Moore-decoded from the registered state, opcode, cond and status flags.
module control_unit #(
  parameter int READ_WAIT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] current_instruction,
  input  logic        Z_in,
  input  logic        N_in,
  input  logic        resume,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        fetch_instruction,
  output logic        alu_override_imm8,
  output logic        alu_override_imm4,
  output logic        alu_set_flags,
  output logic        set_pc,
  output logic        pc_from_register,
  output logic        mem_write,
  output logic        mem_write_is_stack,
  output logic        mem_write_next_pc,
  output logic        set_sp,
  output logic        increase_sp,
  output logic        halted,
  output logic        illegal,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    WAIT,
    SPINC,
    EXEC,
    EXEC2,
    HALT
  } stateT;

  localparam int            CW         = (READ_WAIT > 0) ? $clog2(READ_WAIT + 1) : 1;
  localparam logic [CW-1:0] FETCH_LAST = CW'(READ_WAIT);
  localparam logic [CW-1:0] WAIT_LAST  = CW'((READ_WAIT > 0) ? READ_WAIT - 1 : 0);
  localparam bit            HAS_WAIT   = (READ_WAIT > 0);

  localparam logic [3:0] OP_ALU   = 4'h0;
  localparam logic [3:0] OP_IMM4  = 4'h1;
  localparam logic [3:0] OP_IMM8  = 4'h2;
  localparam logic [3:0] OP_LOAD  = 4'h3;
  localparam logic [3:0] OP_STORE = 4'h4;
  localparam logic [3:0] OP_PUSH  = 4'h5;
  localparam logic [3:0] OP_POP   = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_CALL  = 4'h9;

  stateT         state_q, state_d;
  logic [CW-1:0] waitCnt_q, waitCnt_d;
  logic          running_q;
  logic          illegal_q;
  logic [15:0]   retired_q;
  logic          retire;
  logic          setIllegal;

  logic [3:0] opcode;
  logic [3:0] cond;
  logic       jmpTaken;
  logic       unusedOperandBits;

  assign opcode            = current_instruction[15:12];
  assign cond              = current_instruction[3:0];
  assign unusedOperandBits = ^current_instruction[11:4];

  always_comb begin
    case (cond)
      4'h0:    jmpTaken = 1'b1;
      4'h1:    jmpTaken = Z_in;
      4'h2:    jmpTaken = !Z_in;
      4'h3:    jmpTaken = N_in;
      4'h4:    jmpTaken = !N_in;
      default: jmpTaken = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    retire     = 1'b0;
    setIllegal = 1'b0;
    if (running_q) begin
      case (state_q)
        FETCH: begin
          if (waitCnt_q == FETCH_LAST) begin
            waitCnt_d = '0;
            state_d   = DECODE;
          end else begin
            waitCnt_d = waitCnt_q + CW'(1);
          end
        end
        DECODE: begin
          case (opcode)
            OP_LOAD: state_d = HAS_WAIT ? WAIT : EXEC;
            OP_POP:  state_d = SPINC;
            OP_HALT: begin
              state_d = HALT;
              retire  = 1'b1;
            end
            OP_ALU, OP_IMM4, OP_IMM8, OP_STORE, OP_PUSH, OP_JMP, OP_CALL: state_d = EXEC;
            default: begin
              state_d    = EXEC;
              setIllegal = 1'b1;
            end
          endcase
        end
        SPINC: state_d = HAS_WAIT ? WAIT : EXEC;
        WAIT: begin
          if (waitCnt_q == WAIT_LAST) begin
            waitCnt_d = '0;
            state_d   = EXEC;
          end else begin
            waitCnt_d = waitCnt_q + CW'(1);
          end
        end
        EXEC: begin
          if (opcode == OP_CALL) begin
            state_d = EXEC2;
          end else begin
            state_d = FETCH;
            retire  = 1'b1;
          end
        end
        EXEC2: begin
          state_d = FETCH;
          retire  = 1'b1;
        end
        HALT: begin
          if (resume) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_comb begin
    reg_write          = 1'b0;
    mem_to_reg         = 1'b0;
    fetch_instruction  = 1'b0;
    alu_override_imm8  = 1'b0;
    alu_override_imm4  = 1'b0;
    alu_set_flags      = 1'b0;
    set_pc             = 1'b0;
    pc_from_register   = 1'b0;
    mem_write          = 1'b0;
    mem_write_is_stack = 1'b0;
    mem_write_next_pc  = 1'b0;
    set_sp             = 1'b0;
    increase_sp        = 1'b0;
    halted             = 1'b0;
    if (running_q) begin
      case (state_q)
        FETCH: begin
          fetch_instruction = 1'b1;
          set_pc            = (waitCnt_q == FETCH_LAST);
        end
        SPINC: begin
          set_sp      = 1'b1;
          increase_sp = 1'b1;
        end
        EXEC: begin
          case (opcode)
            OP_ALU: begin
              reg_write     = 1'b1;
              alu_set_flags = 1'b1;
            end
            OP_IMM4: begin
              reg_write         = 1'b1;
              alu_set_flags     = 1'b1;
              alu_override_imm4 = 1'b1;
            end
            OP_IMM8: begin
              reg_write         = 1'b1;
              alu_override_imm8 = 1'b1;
            end
            OP_LOAD, OP_POP: begin
              reg_write  = 1'b1;
              mem_to_reg = 1'b1;
            end
            OP_STORE: mem_write = 1'b1;
            OP_PUSH: begin
              mem_write          = 1'b1;
              mem_write_is_stack = 1'b1;
              set_sp             = 1'b1;
            end
            OP_JMP: begin
              set_pc           = jmpTaken;
              pc_from_register = jmpTaken;
            end
            OP_CALL: begin
              mem_write          = 1'b1;
              mem_write_is_stack = 1'b1;
              mem_write_next_pc  = 1'b1;
              set_sp             = 1'b1;
            end
            default: ;
          endcase
        end
        EXEC2: begin
          set_pc           = 1'b1;
          pc_from_register = 1'b1;
        end
        HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

  // running_q gives one quiet cycle after reset, with every output low, before fetching.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= FETCH;
      waitCnt_q <= '0;
      running_q <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      running_q <= 1'b1;
      if (setIllegal) illegal_q <= 1'b1;
      if (retire) retired_q <= retired_q + 16'd1;
    end
  end

  assign illegal = illegal_q;
  assign retired = retired_q;

  memWriteNotFetch: assert property (@(posedge clock) disable iff (reset)
    !(mem_write && fetch_instruction));
  setPcNotNextPc: assert property (@(posedge clock) disable iff (reset)
    !(set_pc && mem_write_next_pc));
  incSpNeedsSetSp: assert property (@(posedge clock) disable iff (reset)
    !(increase_sp && !set_sp));
  noWriteWhileHalted: assert property (@(posedge clock) disable iff (reset)
    !(reg_write && halted));

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle sequencer that drives every control input of the CPU datapath.
- Decodes the datapath's latched current_instruction and Z/N status flags, then steps FETCH -> DECODE -> execute states per opcode.
- Sits beside the datapath in the CPU top. Also provides halt/resume and an instruction-retired counter for the debug display.

Parameters:
READ_WAIT, 1, memory read latency in cycles (>=0). FETCH, LOAD and POP hold the read address this many extra cycles before using the data.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
current_instruction  in  16  instruction latched by datapath
Z_in  in  1  zero flag (SR[1])
N_in  in  1  negative flag (SR[2])
resume  in  1  leave HALT on next clock
reg_write  out  1  write r1
mem_to_reg  out  1  register write data from memory
fetch_instruction  out  1  memory read address = PC; latch instruction
alu_override_imm8  out  1  ALU output = sign-extended imm8
alu_override_imm4  out  1  ALU b = zero-extended imm4
alu_set_flags  out  1  update SR flags
set_pc  out  1  load next PC
pc_from_register  out  1  next PC = r1 value
mem_write  out  1  memory write strobe
mem_write_is_stack  out  1  write address = SP
mem_write_next_pc  out  1  write data = next PC
set_sp  out  1  update SP
increase_sp  out  1  SP+1 (else SP-1)
halted  out  1  high while in HALT
illegal  out  1  sticky; set on undefined opcode
retired  out  16  instructions completed, wraps 0xFFFF->0

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset forces state FETCH, wait counter 0, all control outputs 0, halted 0, illegal 0, retired 0.
- Reset beats every other event, including mid-instruction and during HALT.
- All control outputs are Moore, decoded from state, opcode (current_instruction[15:12]) and cond (current_instruction[3:0]). Unlisted outputs are 0 in every state.
- FETCH lasts READ_WAIT+1 cycles:
  - fetch_instruction=1 on every FETCH cycle.
  - set_pc=1 only on the final cycle, with pc_from_register=0.
  - Then go to DECODE.
- DECODE: 1 cycle, no outputs asserted. Selects the execute path.
- Execute paths:
  - 0x0 ALU reg-reg, EXEC: reg_write=1, alu_set_flags=1.
  - 0x1 ALU imm4, EXEC: reg_write=1, alu_set_flags=1, alu_override_imm4=1.
  - 0x2 IMM8, EXEC: reg_write=1, alu_override_imm8=1. Flags untouched.
  - 0x3 LOAD r1<-mem[r2]: WAIT for READ_WAIT cycles, then EXEC with mem_to_reg=1, reg_write=1.
  - 0x4 STORE mem[r1]<-r2, EXEC: mem_write=1.
  - 0x5 PUSH r2, EXEC: mem_write=1, mem_write_is_stack=1, set_sp=1, increase_sp=0.
  - 0x6 POP r1 (assembler encodes r2=4'hD, SP): SPINC with set_sp=1, increase_sp=1. Then WAIT for READ_WAIT cycles. Then EXEC with mem_to_reg=1, reg_write=1.
  - 0x7 HALT: enter HALT, halted=1. Stay in HALT until resume=1 is sampled, then go to FETCH. Retired increments on HALT entry.
  - 0x8 JMP r1, EXEC: cond 0=always, 1=Z, 2=!Z, 3=N, 4=!N, 5-F=never. If taken, set_pc=1 and pc_from_register=1. Flags are sampled during EXEC.
  - 0x9 CALL r1: EXEC with mem_write=1, mem_write_is_stack=1, mem_write_next_pc=1, set_sp=1, increase_sp=0. This writes PC (already incremented) to the stack. Then EXEC2 with set_pc=1, pc_from_register=1.
  - 0xA-0xF: illegal<=1 in DECODE, execute as NOP, return to FETCH.
- retired increments by 1 on the last cycle of every instruction, including NOP, not-taken JMP and HALT entry.
- Cycle counts with W=READ_WAIT:
  - ALU/IMM8/STORE/PUSH/JMP: W+3.
  - LOAD: 2W+3.
  - POP: 2W+4.
  - CALL: W+4.
- Invariants (checked by assertions):
  - mem_write never with fetch_instruction.
  - set_pc never coincides with mem_write_next_pc.
  - increase_sp=1 only when set_sp=1.
  - reg_write never while halted.
- resume outside HALT is ignored.

Test Plan:
- Reset held 3 cycles during CALL EXEC2 -> every output 0 the cycle after reset; FETCH restarts; retired=0; illegal=0.
- W=1, instr 0x0123 (ALU) -> fetch_instruction cycles 0-1, set_pc cycle 1, reg_write+alu_set_flags cycle 3, retired 0->1.
- JMP 0x8401 with Z_in=1, then with Z_in=0 -> first: set_pc=1 and pc_from_register=1 in EXEC; second: both stay 0; retired +1 each.
- W=2, POP 0x63D0 -> set_sp+increase_sp cycle 4, idle cycles 5-6, mem_to_reg+reg_write cycle 7 (8 cycles total).
- CALL 0x9500 -> EXEC: mem_write, mem_write_is_stack, mem_write_next_pc, set_sp=1, increase_sp=0; next cycle: set_pc=1, pc_from_register=1.
- HALT 0x7000 then 0xB000 -> halted stays 1 for 10 idle cycles; resume pulse -> FETCH next cycle; 0xB000 sets illegal sticky; retired=2 after it.
